bp_me_stream_pump_out: RTL and testbench

Transmit-side companion to the inbound stream pump. It accepts header and data beats from a producer FSM and drives an outbound BedRock Stream channel through a registered two-entry buffer. It expands single FSM beats into multi-beat messages, or collapses multi-beat FSM output into single messages, according to per-message-type masks. It also gives the FSM beat count, first and last controls. It sits between cache/IO engine FSMs and the BedRock network outputs.

---
 rtl/bp_me_stream_pump_out_pkg.sv | 71 +++++++
 rtl/bp_me_stream_pump_out_if.sv | 18 +
 rtl/bp_me_stream_pump_out_control.sv | 48 ++++
 rtl/bp_me_stream_pump_out_fifo.sv | 61 ++++++
 rtl/bp_me_stream_pump_out.sv | 123 ++++++++++++
 tb/tb_bp_me_stream_pump_out.sv | 370 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/bp_me_stream_pump_out_pkg.sv
// rtl/bp_me_stream_pump_out_pkg.sv - shared types, widths and helpers for the outbound stream pump
//
// Purpose: BedRock header layout, message type/size encodings, stream geometry
// constants, per-type stream mask helpers and the message-size helper used by
// the pump and its bench.
package bp_me_stream_pump_out_pkg;

  localparam int paddr_width_p          = 40;
  localparam int payload_width_p        = 16;
  localparam int stream_data_width_p    = 64;
  localparam int block_width_p          = 512;
  localparam int msg_type_count_lp      = 16;

  localparam int stream_words_lp        = block_width_p / stream_data_width_p;
  localparam int stream_cnt_width_lp    = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
  localparam int stream_bytes_lp        = stream_data_width_p / 8;
  localparam int stream_offset_width_lp = $clog2(stream_bytes_lp);
  localparam int block_offset_width_lp  = $clog2(block_width_p / 8);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bedrock_msg_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bedrock_size_e;

  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    bedrock_size_e              size;
    logic [paddr_width_p-1:0]   addr;
    bedrock_msg_e               msg_type;
  } bedrock_header_s;

  localparam int header_width_lp = $bits(bedrock_header_s);

  // How one FSM beat maps onto the outbound channel for the current message.
  typedef enum logic [1:0] {
    e_pump_1to1 = 2'd0,
    e_pump_1ton = 2'd1,
    e_pump_nto1 = 2'd2
  } pump_mode_e;

  localparam logic [msg_type_count_lp-1:0] mem_rd_stream_mask    = 16'b1 << e_bedrock_mem_rd;
  localparam logic [msg_type_count_lp-1:0] mem_wr_stream_mask    = 16'b1 << e_bedrock_mem_wr;
  localparam logic [msg_type_count_lp-1:0] mem_uc_rd_stream_mask = 16'b1 << e_bedrock_mem_uc_rd;
  localparam logic [msg_type_count_lp-1:0] mem_uc_wr_stream_mask = 16'b1 << e_bedrock_mem_uc_wr;

  // Beats in the message minus one; sub-beat sizes collapse to a single beat
  // and anything larger than a block is clipped to one block.
  function automatic logic [stream_cnt_width_lp-1:0] stream_size(input bedrock_size_e size);
    int beats;
    beats = (1 << int'(size)) / stream_bytes_lp;
    if (beats < 1) beats = 1;
    if (beats > stream_words_lp) beats = stream_words_lp;
    return stream_cnt_width_lp'(beats - 1);
  endfunction

endpackage

// File: rtl/bp_me_stream_pump_out_if.sv
// rtl/bp_me_stream_pump_out_if.sv - outbound BedRock stream channel
//
// Purpose: one outbound stream beat (header, data, last) with valid/ready_and
// handshake.
// Ports (master drives): header, data, v, last; (slave drives): ready_and.
interface bp_me_stream_pump_out_if;
  import bp_me_stream_pump_out_pkg::*;

  bedrock_header_s                header;
  logic [stream_data_width_p-1:0] data;
  logic                           v;
  logic                           last;
  logic                           ready_and;

  modport master (output header, output data, output v, output last, input ready_and);
  modport slave  (input header, input data, input v, input last, output ready_and);

endinterface

// File: rtl/bp_me_stream_pump_out_control.sv
// rtl/bp_me_stream_pump_out_control.sv - wrapping beat counter with first/last tracking
//
// Purpose: tracks the beat index within a block and the position inside the
// current message.
// Ports: clk_i, reset_i; size_i (beats-1), cnt_load_i (critical word offset),
// en_i (advance one beat); cnt_o (current beat index), first_o, last_o.
module bp_me_stream_pump_out_control
  import bp_me_stream_pump_out_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [stream_cnt_width_lp-1:0] size_i,
  input  logic [stream_cnt_width_lp-1:0] cnt_load_i,
  input  logic                           en_i,
  output logic [stream_cnt_width_lp-1:0] cnt_o,
  output logic                           first_o,
  output logic                           last_o
);

  logic                           first_r;
  logic [stream_cnt_width_lp-1:0] cnt_r;
  logic [stream_cnt_width_lp-1:0] done_r;

  // On the first beat the index comes straight from the address so the
  // critical word is presented without waiting for a load cycle.
  assign first_o = first_r;
  assign cnt_o   = first_r ? cnt_load_i : cnt_r;
  assign last_o  = (done_r == size_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      first_r <= 1'b1;
      cnt_r   <= '0;
      done_r  <= '0;
    end else if (en_i) begin
      cnt_r <= (cnt_o == stream_cnt_width_lp'(stream_words_lp - 1))
             ? '0 : cnt_o + stream_cnt_width_lp'(1);
      if (last_o) begin
        first_r <= 1'b1;
        done_r  <= '0;
      end else begin
        first_r <= 1'b0;
        done_r  <= done_r + stream_cnt_width_lp'(1);
      end
    end
  end

endmodule

// File: rtl/bp_me_stream_pump_out_fifo.sv
// rtl/bp_me_stream_pump_out_fifo.sv - two-entry registered output buffer
//
// Purpose: decouples the pump from the network with one cycle of latency and
// full throughput.
// Ports: clk_i, reset_i; data_i/v_i/ready_o (enqueue side, ready_o is
// registered); data_o/v_o/yumi_i (dequeue side, yumi_i only when v_o).
module bp_me_stream_pump_out_fifo #(
  parameter int width_p = 1
)
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic               full_r;
  logic               empty_r;
  logic               enq;
  logic               deq;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ~full_r;
  assign deq     = yumi_i & ~empty_r;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      // Simultaneous enqueue and dequeue leave the occupancy unchanged.
      if (enq & ~deq) begin
        empty_r <= 1'b0;
        full_r  <= ~empty_r;
      end else if (deq & ~enq) begin
        full_r  <= 1'b0;
        empty_r <= ~full_r;
      end
    end
  end

endmodule

// File: rtl/bp_me_stream_pump_out.sv
// rtl/bp_me_stream_pump_out.sv - FSM-to-BedRock outbound stream pump
//
// Purpose: accepts header/data beats from an engine FSM and drives the outbound
// stream through a two-entry buffer, expanding (1:N) or collapsing (N:1) beats
// according to the per-type masks.
// Ports: clk_i, reset_i; fsm_header_i/fsm_data_i/fsm_v_i/fsm_ready_and_o (FSM
// beat handshake); fsm_addr_o, fsm_cnt_o, fsm_new_o, fsm_last_o (beat position
// for the FSM); msg (outbound stream, master side).
module bp_me_stream_pump_out
  import bp_me_stream_pump_out_pkg::*;
#(
  parameter logic [msg_type_count_lp-1:0] msg_stream_mask_p = '0,
  parameter logic [msg_type_count_lp-1:0] fsm_stream_mask_p = msg_stream_mask_p
)
(
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  bedrock_header_s                fsm_header_i,
  input  logic [stream_data_width_p-1:0] fsm_data_i,
  input  logic                           fsm_v_i,
  output logic                           fsm_ready_and_o,
  output logic [paddr_width_p-1:0]       fsm_addr_o,
  output logic [stream_cnt_width_lp-1:0] fsm_cnt_o,
  output logic                           fsm_new_o,
  output logic                           fsm_last_o,
  bp_me_stream_pump_out_if.master        msg
);

  localparam int fifo_width_lp = header_width_lp + stream_data_width_p + 1;

  logic [stream_cnt_width_lp-1:0] stream_size_li;
  logic [stream_cnt_width_lp-1:0] cnt_load_li;
  logic                           fsm_stream;
  logic                           msg_stream;
  pump_mode_e                     mode;
  logic                           cnt_en;
  logic                           fifo_v_li;
  logic                           fifo_ready_lo;
  logic                           fifo_last_li;
  logic                           fifo_v_lo;
  logic                           fifo_yumi_li;
  logic [fifo_width_lp-1:0]       fifo_data_li;
  logic [fifo_width_lp-1:0]       fifo_data_lo;

  assign stream_size_li = stream_size(fsm_header_i.size);
  assign fsm_stream     = fsm_stream_mask_p[fsm_header_i.msg_type] & (stream_size_li != '0);
  assign msg_stream     = msg_stream_mask_p[fsm_header_i.msg_type] & (stream_size_li != '0);
  assign mode           = (msg_stream & ~fsm_stream) ? e_pump_1ton
                        : (fsm_stream & ~msg_stream) ? e_pump_nto1
                        : e_pump_1to1;

  // Critical-word offset: the beat index the message starts from.
  assign cnt_load_li = fsm_header_i.addr[stream_offset_width_lp +: stream_cnt_width_lp];

  bp_me_stream_pump_out_control control (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .size_i     (stream_size_li),
    .cnt_load_i (cnt_load_li),
    .en_i       (cnt_en),
    .cnt_o      (fsm_cnt_o),
    .first_o    (fsm_new_o),
    .last_o     (fsm_last_o)
  );

  assign fsm_addr_o = {fsm_header_i.addr[paddr_width_p-1:block_offset_width_lp],
                       fsm_cnt_o,
                       fsm_header_i.addr[stream_offset_width_lp-1:0]};

  always_comb begin
    fifo_v_li       = 1'b0;
    fifo_last_li    = fsm_last_o;
    fsm_ready_and_o = 1'b0;
    cnt_en          = 1'b0;
    unique case (mode)
      // One FSM beat is replayed into every msg beat; the FSM is only released
      // once the final copy is enqueued.
      e_pump_1ton: begin
        fifo_v_li       = fsm_v_i;
        fsm_ready_and_o = fifo_ready_lo & fsm_last_o;
        cnt_en          = fsm_v_i & fifo_ready_lo;
      end
      // Only the last FSM beat reaches the buffer; earlier beats are consumed
      // without looking at buffer space.
      e_pump_nto1: begin
        fifo_v_li       = fsm_v_i & fsm_last_o;
        fifo_last_li    = 1'b1;
        fsm_ready_and_o = ~fsm_last_o | fifo_ready_lo;
        cnt_en          = fsm_v_i & fsm_ready_and_o;
      end
      default: begin
        fifo_v_li       = fsm_v_i;
        fsm_ready_and_o = fifo_ready_lo;
        cnt_en          = fsm_v_i & fifo_ready_lo;
      end
    endcase
    if (reset_i) begin
      fifo_v_li       = 1'b0;
      fsm_ready_and_o = 1'b0;
      cnt_en          = 1'b0;
    end
  end

  assign fifo_data_li = {fsm_header_i, fsm_data_i, fifo_last_li};

  bp_me_stream_pump_out_fifo #(
    .width_p (fifo_width_lp)
  ) buffer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (fifo_data_li),
    .v_i     (fifo_v_li),
    .ready_o (fifo_ready_lo),
    .data_o  (fifo_data_lo),
    .v_o     (fifo_v_lo),
    .yumi_i  (fifo_yumi_li)
  );

  assign fifo_yumi_li = fifo_v_lo & msg.ready_and;
  assign msg.v        = fifo_v_lo;
  assign {msg.header, msg.data, msg.last} = fifo_data_lo;

endmodule

// File: tb/tb_bp_me_stream_pump_out.sv
// tb/tb_bp_me_stream_pump_out.sv - self-checking bench for the outbound stream pump
module tb_bp_me_stream_pump_out;
  import bp_me_stream_pump_out_pkg::*;

  localparam int tmo_lp = 200;
  localparam logic [msg_type_count_lp-1:0] msg_mask_lp = mem_rd_stream_mask | mem_wr_stream_mask;
  localparam logic [msg_type_count_lp-1:0] fsm_mask_lp = mem_wr_stream_mask | mem_uc_rd_stream_mask;

  typedef struct packed {
    bedrock_header_s                header;
    logic [stream_data_width_p-1:0] data;
    logic                           last;
  } beat_s;

  logic                           clk = 1'b0;
  logic                           reset_i;
  bedrock_header_s                fsm_header_i;
  logic [stream_data_width_p-1:0] fsm_data_i;
  logic                           fsm_v_i;
  logic                           fsm_ready_and_o;
  logic [paddr_width_p-1:0]       fsm_addr_o;
  logic [stream_cnt_width_lp-1:0] fsm_cnt_o;
  logic                           fsm_new_o;
  logic                           fsm_last_o;

  bp_me_stream_pump_out_if msg_if ();

  bp_me_stream_pump_out #(
    .msg_stream_mask_p (msg_mask_lp),
    .fsm_stream_mask_p (fsm_mask_lp)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .fsm_header_i    (fsm_header_i),
    .fsm_data_i      (fsm_data_i),
    .fsm_v_i         (fsm_v_i),
    .fsm_ready_and_o (fsm_ready_and_o),
    .fsm_addr_o      (fsm_addr_o),
    .fsm_cnt_o       (fsm_cnt_o),
    .fsm_new_o       (fsm_new_o),
    .fsm_last_o      (fsm_last_o),
    .msg             (msg_if)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  beat_s exp_q[$];
  int    enq_cnt = 0;
  int    deq_cnt = 0;
  logic  chk_occ = 1'b0;

  // Scoreboard: every outbound transfer is popped against the expected queue.
  initial begin : monitor
    beat_s exp_b;
    beat_s act_b;
    forever begin
      @(negedge clk);
      if (chk_occ && (enq_cnt - deq_cnt) >= 2) begin
        total++;
        if (fsm_ready_and_o !== 1'b0) begin
          bad++;
          $display("FAIL full_buffer_ready got=%b want=0 occ=%0d", fsm_ready_and_o, enq_cnt - deq_cnt);
        end
      end
      if (reset_i === 1'b0 && msg_if.v === 1'b1 && msg_if.ready_and === 1'b1) begin
        deq_cnt++;
        total++;
        act_b = {msg_if.header, msg_if.data, msg_if.last};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_msg_beat got=%h", act_b);
        end else begin
          exp_b = exp_q.pop_front();
          if (act_b !== exp_b) begin
            bad++;
            $display("FAIL msg_beat got=%h want=%h", act_b, exp_b);
          end
        end
      end
    end
  end

  function automatic bedrock_header_s mk_hdr(input bedrock_msg_e t, input bedrock_size_e s,
                                             input logic [paddr_width_p-1:0] addr);
    bedrock_header_s h;
    h.msg_type = t;
    h.size     = s;
    h.addr     = addr;
    h.payload  = addr[15:0] ^ 16'h5a5a;
    return h;
  endfunction

  // Presents one FSM beat and holds it until fsm_ready_and_o (or timeout);
  // w returns the number of cycles the beat was held off.
  task automatic fsm_beat(input bedrock_header_s h, input logic [stream_data_width_p-1:0] d,
                          output logic [stream_cnt_width_lp-1:0] c, output logic nw,
                          output logic ls, output logic [paddr_width_p-1:0] a, output int w);
    fsm_header_i = h;
    fsm_data_i   = d;
    fsm_v_i      = 1'b1;
    w = 0;
    @(negedge clk);
    while (fsm_ready_and_o !== 1'b1 && w < tmo_lp) begin
      w++;
      @(negedge clk);
    end
    c  = fsm_cnt_o;
    nw = fsm_new_o;
    ls = fsm_last_o;
    a  = fsm_addr_o;
    @(posedge clk);
    if (w < tmo_lp) enq_cnt++;
    #1;
    fsm_v_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    msg_if.ready_and = 1'b1;
    while (exp_q.size() != 0 && n < tmo_lp) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s left=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // 64B 1:1 write of 8 beats; bp means the downstream is stalling.
  task automatic run_wr64(input logic [paddr_width_p-1:0] addr, input logic [31:0] tag, input logic bp);
    bedrock_header_s                h;
    logic [stream_cnt_width_lp-1:0] c;
    logic [stream_cnt_width_lp-1:0] exp_c;
    logic                           nw;
    logic                           ls;
    logic [paddr_width_p-1:0]       a;
    logic [paddr_width_p-1:0]       exp_a;
    int                             w;
    h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, addr);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(beat_s'{header: h, data: {tag, 32'(i)}, last: (i == 7)});
      fsm_beat(h, {tag, 32'(i)}, c, nw, ls, a, w);
      exp_c = addr[5:3] + 3'(i);
      exp_a = {addr[paddr_width_p-1:6], exp_c, addr[2:0]};
      total++;
      if (c !== exp_c) begin
        bad++;
        $display("FAIL wr64_cnt beat=%0d got=%0d want=%0d", i, c, exp_c);
      end
      total++;
      if ({nw, ls} !== {(i == 0), (i == 7)}) begin
        bad++;
        $display("FAIL wr64_new_last beat=%0d got=%b want=%b", i, {nw, ls}, {(i == 0), (i == 7)});
      end
      total++;
      if (a !== exp_a) begin
        bad++;
        $display("FAIL wr64_addr beat=%0d got=%h want=%h", i, a, exp_a);
      end
      total++;
      if (bp ? (w >= tmo_lp) : (w != 0)) begin
        bad++;
        $display("FAIL wr64_accept_wait beat=%0d got=%0d want=%s", i, w, bp ? "<limit" : "0");
      end
    end
  endtask

  task automatic test_reset;
    reset_i          = 1'b1;
    fsm_v_i          = 1'b0;
    fsm_header_i     = '0;
    fsm_data_i       = '0;
    msg_if.ready_and = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({msg_if.v, fsm_ready_and_o, fsm_new_o} !== 3'b001) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=001", {msg_if.v, fsm_ready_and_o, fsm_new_o});
    end
    total++;
    if (fsm_cnt_o !== '0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", fsm_cnt_o);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    total++;
    if ({msg_if.v, fsm_new_o} !== 2'b01) begin
      bad++;
      $display("FAIL post_reset_ctl got=%b want=01", {msg_if.v, fsm_new_o});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_to_one;
    msg_if.ready_and = 1'b1;
    run_wr64(40'h1010, 32'h0000_0001, 1'b0);
    drain("one_to_one");
  endtask

  task automatic test_one_to_n;
    bedrock_header_s                h;
    logic [stream_cnt_width_lp-1:0] c;
    logic                           nw;
    logic                           ls;
    logic [paddr_width_p-1:0]       a;
    int                             w;
    msg_if.ready_and = 1'b1;
    h = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h2000);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(beat_s'{header: h, data: 64'hdead_beef_0000_2000, last: (i == 7)});
    end
    fsm_beat(h, 64'hdead_beef_0000_2000, c, nw, ls, a, w);
    total++;
    if (w != 7) begin
      bad++;
      $display("FAIL one_to_n_ready_cycle got=%0d want=7", w);
    end
    total++;
    if ({c, nw, ls} !== {3'd7, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL one_to_n_final got=%b want=%b", {c, nw, ls}, {3'd7, 1'b0, 1'b1});
    end
    drain("one_to_n");
  endtask

  task automatic test_n_to_one;
    bedrock_header_s                h;
    logic [stream_cnt_width_lp-1:0] c;
    logic [stream_cnt_width_lp-1:0] exp_c;
    logic                           nw;
    logic                           ls;
    logic [paddr_width_p-1:0]       a;
    int                             w;
    msg_if.ready_and = 1'b0;
    h = mk_hdr(e_bedrock_mem_uc_rd, e_bedrock_msg_size_64, 40'h3018);
    exp_q.push_back(beat_s'{header: h, data: 64'h3333_0000_0000_0007, last: 1'b1});
    for (int i = 0; i < 8; i++) begin
      fsm_beat(h, 64'h3333_0000_0000_0000 | 64'(i), c, nw, ls, a, w);
      exp_c = 3'd3 + 3'(i);
      total++;
      if (w != 0) begin
        bad++;
        $display("FAIL n_to_one_ack beat=%0d got=%0d want=0", i, w);
      end
      total++;
      if ({c, nw, ls} !== {exp_c, (i == 0), (i == 7)}) begin
        bad++;
        $display("FAIL n_to_one_pos beat=%0d got=%b want=%b", i, {c, nw, ls}, {exp_c, (i == 0), (i == 7)});
      end
      if (i == 6) begin
        @(negedge clk);
        total++;
        if (msg_if.v !== 1'b0) begin
          bad++;
          $display("FAIL n_to_one_silent got=%b want=0", msg_if.v);
        end
        @(posedge clk);
        #1;
      end
    end
    drain("n_to_one");
  endtask

  task automatic test_backpressure;
    logic done;
    done = 1'b0;
    enq_cnt = 0;
    deq_cnt = 0;
    msg_if.ready_and = 1'b1;
    chk_occ = 1'b1;
    fork
      begin
        run_wr64(40'h1010, 32'h0000_0004, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          msg_if.ready_and = ~msg_if.ready_and;
        end
      end
    join
    drain("backpressure");
    chk_occ = 1'b0;
  endtask

  task automatic test_back_to_back;
    bedrock_header_s                h;
    logic [stream_cnt_width_lp-1:0] c;
    logic                           nw;
    logic                           ls;
    logic [paddr_width_p-1:0]       a;
    int                             w;
    msg_if.ready_and = 1'b1;
    h = mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h4008);
    exp_q.push_back(beat_s'{header: h, data: 64'h5555_aaaa_0000_0008, last: 1'b1});
    fsm_beat(h, 64'h5555_aaaa_0000_0008, c, nw, ls, a, w);
    total++;
    if ({nw, ls, c} !== {1'b1, 1'b1, 3'd1} || w != 0) begin
      bad++;
      $display("FAIL single_beat got=%b wait=%0d want=111001 wait=0", {nw, ls, c}, w);
    end
    run_wr64(40'h5000, 32'h0000_0005, 1'b0);
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_message;
    bedrock_header_s                h;
    logic [stream_cnt_width_lp-1:0] c;
    logic                           nw;
    logic                           ls;
    logic [paddr_width_p-1:0]       a;
    int                             w;
    msg_if.ready_and = 1'b1;
    h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h6000);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(beat_s'{header: h, data: {32'h6, 32'(i)}, last: 1'b0});
      fsm_beat(h, {32'h6, 32'(i)}, c, nw, ls, a, w);
    end
    drain("pre_reset");
    msg_if.ready_and = 1'b0;
    fsm_beat(h, {32'h6, 32'd2}, c, nw, ls, a, w);
    total++;
    if ({c, nw, ls} !== {3'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL third_beat_pos got=%b want=%b", {c, nw, ls}, {3'd2, 1'b0, 1'b0});
    end
    reset_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({msg_if.v, fsm_ready_and_o, fsm_new_o} !== 3'b001) begin
      bad++;
      $display("FAIL mid_reset_ctl got=%b want=001", {msg_if.v, fsm_ready_and_o, fsm_new_o});
    end
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    drain("after_reset");
    run_wr64(40'h6028, 32'h0000_0007, 1'b0);
    drain("post_reset_msg");
  endtask

  initial begin
    test_reset;
    test_one_to_one;
    test_one_to_n;
    test_n_to_one;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_message;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
